// File: rtl/udp_rx_pkg.sv
// Shared constants, state encodings and header field helpers for the UDP receive path.
package udp_rx_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned KEEP_W    = 8;
    localparam int unsigned HDR_BYTES = 42;

    // Header ends mid-beat: payload starts at this beat and lane.
    localparam logic [2:0]  PAYLOAD_BEAT = 3'(HDR_BYTES / 8);
    localparam int unsigned PAYLOAD_LANE = HDR_BYTES % 8;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

    localparam logic [2:0]  ETH_TYPE_BEAT  = 3'd1;
    localparam int unsigned ETH_TYPE_LANE  = 4;
    localparam int unsigned IP_VER_LANE    = 6;
    localparam logic [2:0]  IP_PROTO_BEAT  = 3'd2;
    localparam int unsigned IP_PROTO_LANE  = 7;
    localparam logic [2:0]  UDP_DPORT_BEAT = 3'd4;
    localparam int unsigned UDP_DPORT_LANE = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_HDR     = 2'd0;
    localparam state_t ST_PAYLOAD = 2'd1;
    localparam state_t ST_FLUSH   = 2'd2;
    localparam state_t ST_DROP    = 2'd3;

    function automatic logic [7:0] lane_byte(input logic [DATA_W-1:0] d, input int unsigned lane);
        return d[lane*8 +: 8];
    endfunction

    // Big-endian 16-bit field starting at the given lane.
    function automatic logic [15:0] lane_be16(input logic [DATA_W-1:0] d, input int unsigned lane);
        return {d[lane*8 +: 8], d[(lane+1)*8 +: 8]};
    endfunction

    function automatic logic [3:0] keep_bytes(input logic [KEEP_W-1:0] k);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < int'(KEEP_W); i++) n = n + 4'(k[i]);
        return n;
    endfunction

endpackage

// File: rtl/udp_rx_realign.sv
// Two-byte realign: holds the previous beat and merges it with the current one, and
// produces the trailing flush beat with its reduced byte enables.
module udp_rx_realign
    import udp_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] cur_tdata,
    input  logic [KEEP_W-1:0] cur_tkeep,
    input  logic              cur_tlast,
    input  logic              load,
    input  logic              flush,
    output logic [DATA_W-1:0] beat_data_c,
    output logic [KEEP_W-1:0] beat_keep_c,
    output logic              short_last_c
);

    localparam int unsigned SH = PAYLOAD_LANE * 8;

    logic [DATA_W-1:0] hold;
    logic [KEEP_W-1:0] last_keep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            last_keep <= '0;
        end else if (load) begin
            hold      <= cur_tdata;
            last_keep <= cur_tkeep;
        end
    end

    // A last beat whose bytes all fit in the header-offset lanes closes the frame without a flush.
    assign short_last_c = cur_tlast && (cur_tkeep[KEEP_W-1:PAYLOAD_LANE] == '0);

    always_comb begin
        beat_data_c = {cur_tdata[SH-1:0], hold[DATA_W-1:SH]};
        beat_keep_c = '1;
        if (flush) begin
            beat_data_c = hold >> SH;
            beat_keep_c = last_keep >> PAYLOAD_LANE;
        end else if (short_last_c) begin
            beat_keep_c = {cur_tkeep[PAYLOAD_LANE-1:0], {(KEEP_W-PAYLOAD_LANE){1'b1}}};
        end
    end

endmodule

// File: rtl/udp_to_dac_stream.sv
// Ethernet/IPv4/UDP receive stripper: validates headers, drops foreign frames, realigns payload.
// Optional UDP length check enabled by defining UDP_RX_LEN_CHECK_EN.
module udp_to_dac_stream
    import udp_rx_pkg::*;
#(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int unsigned C_M00_AXIS_TKEEP_WIDTH = 8,
    parameter int unsigned UDP_PORT               = 60133,
    parameter int unsigned CNT_WIDTH              = 32
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tkeep,
    input  logic                                s00_axis_tvalid,
    input  logic                                s00_axis_tlast,
    input  logic                                s00_axis_tuser,
    output logic                                s00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TKEEP_WIDTH-1:0]   m00_axis_tkeep,
    output logic                                m00_axis_tvalid,
    output logic                                m00_axis_tlast,
    output logic                                m00_axis_tuser,
    input  logic                                m00_axis_tready,
    output logic [CNT_WIDTH-1:0]                pkt_count,
    output logic [CNT_WIDTH-1:0]                drop_count
`ifdef UDP_RX_LEN_CHECK_EN
    ,
    output logic [CNT_WIDTH-1:0]                len_err_count
`endif
);

    state_t      state, state_d;
    logic [2:0]  beat_cnt, beat_cnt_d;
    logic        bad, bad_d;
    logic        last_user;
    logic        s_ready, slot_free, hdr_bad_c;
    logic        hold_load, flush, emit, emit_last, emit_user_c, drop_inc, len_err_c;
    logic [DATA_W-1:0] rl_data;
    logic [KEEP_W-1:0] rl_keep;
    logic              rl_short;

    udp_rx_realign u_realign (
        .clk          (s00_axis_aclk),
        .rst_n        (s00_axis_aresetn),
        .cur_tdata    (s00_axis_tdata),
        .cur_tkeep    (s00_axis_tkeep),
        .cur_tlast    (s00_axis_tlast),
        .load         (hold_load),
        .flush        (flush),
        .beat_data_c  (rl_data),
        .beat_keep_c  (rl_keep),
        .short_last_c (rl_short)
    );

    assign slot_free       = !m00_axis_tvalid || m00_axis_tready;
    assign s00_axis_tready = s_ready;
    assign emit_user_c     = (flush ? last_user : s00_axis_tuser) | len_err_c;

    // Per-beat header field check.
    always_comb begin
        hdr_bad_c = 1'b0;
        if (beat_cnt == ETH_TYPE_BEAT)
            hdr_bad_c = (lane_be16(s00_axis_tdata, ETH_TYPE_LANE) != ETHERTYPE_IPV4) ||
                        (lane_byte(s00_axis_tdata, IP_VER_LANE) != IP_VER_IHL);
        else if (beat_cnt == IP_PROTO_BEAT)
            hdr_bad_c = lane_byte(s00_axis_tdata, IP_PROTO_LANE) != IP_PROTO_UDP;
        else if (beat_cnt == UDP_DPORT_BEAT)
            hdr_bad_c = lane_be16(s00_axis_tdata, UDP_DPORT_LANE) != 16'(UDP_PORT);
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state     <= ST_HDR;
            beat_cnt  <= '0;
            bad       <= 1'b0;
            last_user <= 1'b0;
        end else begin
            state    <= state_d;
            beat_cnt <= beat_cnt_d;
            bad      <= bad_d;
            if (hold_load) last_user <= s00_axis_tuser;
        end
    end

    always_comb begin
        state_d    = state;
        beat_cnt_d = beat_cnt;
        bad_d      = bad;
        s_ready    = 1'b0;
        hold_load  = 1'b0;
        flush      = 1'b0;
        emit       = 1'b0;
        emit_last  = 1'b0;
        drop_inc   = 1'b0;
        case (state)
            ST_HDR: begin
                s_ready = 1'b1;
                if (s00_axis_tvalid) begin
                    if (beat_cnt == PAYLOAD_BEAT) begin
                        hold_load  = 1'b1;
                        beat_cnt_d = '0;
                        bad_d      = 1'b0;
                        if (!s00_axis_tlast) state_d = ST_PAYLOAD;
                        else if (!rl_short)  state_d = ST_FLUSH;
                        else                 drop_inc = 1'b1;
                    end else if (s00_axis_tlast) begin
                        drop_inc   = 1'b1;
                        beat_cnt_d = '0;
                        bad_d      = 1'b0;
                    end else if (beat_cnt == UDP_DPORT_BEAT && (bad || hdr_bad_c)) begin
                        state_d    = ST_DROP;
                        beat_cnt_d = '0;
                        bad_d      = 1'b0;
                    end else begin
                        beat_cnt_d = beat_cnt + 3'd1;
                        bad_d      = bad || hdr_bad_c;
                    end
                end
            end
            ST_PAYLOAD: begin
                s_ready = slot_free;
                if (s00_axis_tvalid && slot_free) begin
                    emit      = 1'b1;
                    hold_load = 1'b1;
                    if (s00_axis_tlast) begin
                        if (rl_short) begin
                            emit_last = 1'b1;
                            state_d   = ST_HDR;
                        end else begin
                            state_d   = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    emit      = 1'b1;
                    flush     = 1'b1;
                    emit_last = 1'b1;
                    state_d   = ST_HDR;
                end
            end
            ST_DROP: begin
                s_ready = 1'b1;
                if (s00_axis_tvalid && s00_axis_tlast) begin
                    drop_inc = 1'b1;
                    state_d  = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    // Single output register; loaded only when empty or draining this cycle.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tkeep  <= '0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tuser  <= 1'b0;
        end else if (emit) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= rl_data;
            m00_axis_tkeep  <= rl_keep;
            m00_axis_tlast  <= emit_last;
            m00_axis_tuser  <= emit_last && emit_user_c;
        end else if (m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tuser  <= 1'b0;
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast)
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            if (drop_inc)
                drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

`ifdef UDP_RX_LEN_CHECK_EN
    localparam int unsigned UDP_LEN_LANE = 6;
    localparam logic [15:0] UDP_HDR_LEN  = 16'd8;

    logic [15:0] udp_len, byte_cnt;

    assign len_err_c = (byte_cnt + 16'(keep_bytes(rl_keep))) != (udp_len - UDP_HDR_LEN);

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            udp_len       <= '0;
            byte_cnt      <= '0;
            len_err_count <= '0;
        end else begin
            if (state == ST_HDR && s00_axis_tvalid && beat_cnt == UDP_DPORT_BEAT)
                udp_len <= lane_be16(s00_axis_tdata, UDP_LEN_LANE);
            if (state == ST_HDR)
                byte_cnt <= '0;
            else if (emit)
                byte_cnt <= byte_cnt + 16'(keep_bytes(rl_keep));
            if (emit && emit_last && len_err_c)
                len_err_count <= len_err_count + CNT_WIDTH'(1);
        end
    end
`else
    assign len_err_c = 1'b0;
`endif

endmodule
